// File: rtl/frodo_pkg.sv
// Shared FrodoKEM constants: security-level encodings and per-level log2(q).
package frodo_pkg;

  typedef enum logic [2:0] {
    SEC_640  = 3'd1,
    SEC_976  = 3'd2,
    SEC_1344 = 3'd3
  } sec_lev_e;

  localparam int unsigned LOGQ_640  = 15;
  localparam int unsigned LOGQ_976  = 16;
  localparam int unsigned LOGQ_1344 = 16;

  // Unknown codes fall back to the 2^16 modulus shared by 976/1344.
  function automatic int unsigned logq(input logic [2:0] sec);
    if (sec == SEC_640) return LOGQ_640;
    if (sec == SEC_1344) return LOGQ_1344;
    return LOGQ_976;
  endfunction

endpackage

// File: rtl/tree_add_lane.sv
// One lane of the tree adder: selects the raw operand or the truncated product and registers it.
module tree_add_lane
  import frodo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] array_lane,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lane_q
);

  logic [WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lane_q <= '0;
    else     lane_q <= mode ? prod : array_lane;
  end

endmodule

// File: rtl/tree_add.sv
// Pipelined array-sum / inner-product adder tree with accumulator addend.
// Optional TREE_ADD_SECLEV_MASK_EN applies the Frodo-640 modulus mask on the final stage.
module tree_add
  import frodo_pkg::*;
#(
  parameter int T     = 16,
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [2:0]         i_sec_lev,
  input  logic               i_mode,
  input  logic [WIDTH*T-1:0] i_array,
  input  logic [WIDTH*T-1:0] i_a,
  input  logic [WIDTH*T-1:0] i_b,
  input  logic [WIDTH-1:0]   i_element,
  output logic [WIDTH-1:0]   o_element,
  output logic               o_valid
);

  localparam int unsigned LEVELS = $clog2(T);
  localparam int unsigned NODES  = T - 1;

  logic [WIDTH-1:0] lane_q [T];
  logic [WIDTH-1:0] node   [NODES];
  logic [WIDTH-1:0] elem_d [LEVELS+1];
  logic [LEVELS:0]  vld_d;
  logic [WIDTH-1:0] result;

  for (genvar k = 0; k < T; k++) begin : g_lane
    tree_add_lane #(.WIDTH(WIDTH)) u_lane (
      .clk        (i_clk),
      .rst        (i_rst),
      .mode       (i_mode),
      .array_lane (i_array[k*WIDTH +: WIDTH]),
      .a          (i_a[k*WIDTH +: WIDTH]),
      .b          (i_b[k*WIDTH +: WIDTH]),
      .lane_q     (lane_q[k])
    );
  end

  // Tree levels are stored back to back: level l (1-based) starts at T - (2T >> l).
  function automatic int unsigned base(input int unsigned l);
    return T - ((2 * T) >> l);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned n = 0; n < NODES; n++) node[n] <= '0;
    end else begin
      for (int unsigned j = 0; j < T / 2; j++)
        node[j] <= lane_q[2*j] + lane_q[2*j+1];
      for (int unsigned l = 2; l <= LEVELS; l++)
        for (int unsigned j = 0; j < (T >> l); j++)
          node[base(l)+j] <= node[base(l-1)+2*j] + node[base(l-1)+2*j+1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_d <= '0;
      for (int unsigned i = 0; i <= LEVELS; i++) elem_d[i] <= '0;
    end else begin
      vld_d     <= {vld_d[LEVELS-1:0], i_valid};
      elem_d[0] <= i_element;
      for (int unsigned i = 1; i <= LEVELS; i++) elem_d[i] <= elem_d[i-1];
    end
  end

`ifdef TREE_ADD_SECLEV_MASK_EN
  logic [2:0] sec_d [LEVELS+1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i <= LEVELS; i++) sec_d[i] <= '0;
    end else begin
      sec_d[0] <= i_sec_lev;
      for (int unsigned i = 1; i <= LEVELS; i++) sec_d[i] <= sec_d[i-1];
    end
  end

  always_comb begin
    result = node[NODES-1] + elem_d[LEVELS];
    for (int unsigned bit_i = 0; bit_i < WIDTH; bit_i++)
      if (bit_i >= logq(sec_d[LEVELS])) result[bit_i] = 1'b0;
  end
`else
  logic unused_sec_lev;

  assign unused_sec_lev = ^i_sec_lev;

  always_comb begin
    result = node[NODES-1] + elem_d[LEVELS];
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_element <= '0;
    end else begin
      o_valid <= vld_d[LEVELS];
      if (vld_d[LEVELS]) o_element <= result;
    end
  end

endmodule

// File: tb/tb_tree_add.sv
// Scoreboard bench for tree_add (T=16, WIDTH=16); expectations follow TREE_ADD_SECLEV_MASK_EN.
module tb_tree_add;

  localparam int W   = 16;
  localparam int N   = 16;
  localparam int VW  = W * N;
  localparam int LAT = 6;
`ifdef TREE_ADD_SECLEV_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
    string        name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [2:0]    i_sec_lev = '0;
  logic          i_mode = 1'b0;
  logic [VW-1:0] i_array = '0;
  logic [VW-1:0] i_a = '0;
  logic [VW-1:0] i_b = '0;
  logic [W-1:0]  i_element = '0;
  logic [W-1:0]  o_element;
  logic          o_valid;

  exp_t         sb[$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_out = '0;

  tree_add #(.T(N), .WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .i_sec_lev (i_sec_lev),
    .i_mode    (i_mode),
    .i_array   (i_array),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_element (i_element),
    .o_element (o_element),
    .o_valid   (o_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] fill(input logic [W-1:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(k);
    return r;
  endfunction

  task automatic issue(input logic m, input logic [2:0] s, input logic [W-1:0] el,
                       input logic [VW-1:0] arr, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input bit push, input logic [W-1:0] ev, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = 1'b1; i_mode = m; i_sec_lev = s; i_element = el;
    i_array = arr; i_a = a; i_b = b;
    if (push) begin
      e.val = ev; e.cyc = cyc; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_array = fill(16'hDEAD); i_a = fill(16'hBEEF); i_b = fill(16'h1234);
    end
  endtask

  // Monitor: pops the scoreboard on every o_valid, otherwise checks that the output holds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: o_valid=1 o_element=%h, required no output", o_element);
        end else begin
          e = sb.pop_front();
          if (o_element !== e.val) begin
            fails++;
            $display("FAIL %s: o_element=%h required %h", e.name, o_element, e.val);
          end
          tests++;
          if (cyc - e.cyc != LAT) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles required %0d", e.name, cyc - e.cyc, LAT);
          end
          last_out = e.val;
        end
      end else if (!rst) begin
        tests++;
        if (o_valid !== 1'b0 || o_element !== last_out) begin
          fails++;
          $display("FAIL hold: o_valid=%b o_element=%h required 0 / %h", o_valid, o_element, last_out);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (o_valid !== 1'b0 || o_element !== '0) begin
      fails++;
      $display("FAIL reset_state: o_valid=%b o_element=%h required 0 / 0000", o_valid, o_element);
    end
    rst = 1'b0;
    idle(2);

    issue(1'b0, 3'd1, 16'd16, ramp(), fill(16'hFFFF), fill(16'h0003), 1'b1, 16'd136, "sum_ramp");
    issue(1'b1, 3'd1, 16'd16, fill(16'h7777), ramp(), ramp(), 1'b1, 16'd1256, "dot_ramp");
    idle(1);
    issue(1'b1, 3'd2, 16'd0, ramp(), fill(16'hFFFF), fill(16'hFFFF), 1'b1, 16'd16, "dot_wrap");
    issue(1'b0, 3'd1, 16'h8001, fill(16'h4000), '0, '0, 1'b1,
          MASK_ON ? 16'h0001 : 16'h8001, "mask_640");
    issue(1'b0, 3'd2, 16'h8001, fill(16'h4000), '0, '0, 1'b1, 16'h8001, "nomask_976");
    idle(2);
    issue(1'b0, 3'd3, 16'd5, fill(16'h0800), fill(16'h0002), fill(16'h0002), 1'b1, 16'h8005, "nomask_1344");
    issue(1'b0, 3'd1, 16'd5, fill(16'h0800), fill(16'h0002), fill(16'h0002), 1'b1,
          MASK_ON ? 16'h0005 : 16'h8005, "mask_640_b");
    issue(1'b1, 3'd2, 16'd4, ramp(), fill(16'h0002), fill(16'h0003), 1'b1, 16'd100, "dot_const");
    issue(1'b0, 3'd0, 16'hFFFF, fill(16'h0001), fill(16'hFFFF), fill(16'hFFFF), 1'b1, 16'h000F, "sum_wrap");
    idle(10);

    // Mid-flight reset: the in-flight operand set must never emerge.
    issue(1'b0, 3'd1, 16'd16, ramp(), '0, '0, 1'b0, '0, "");
    idle(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    last_out = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    issue(1'b0, 3'd1, 16'd16, ramp(), '0, '0, 1'b1, 16'd136, "post_reset");
    idle(1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outputs outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tree_add.md
TREE_ADD -- requirements
Module: tree_add

Interface
- REQ-001 SHALL have parameter T, default 16: number of lanes; power of two, at least 2.
- REQ-002 SHALL have parameter WIDTH, default 16: lane and result width in bits.
- REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all logic is rising-edge.
- REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port i_valid, input, 1 bit: operands are valid this cycle.
- REQ-006 SHALL have port i_sec_lev, input, 3 bits: 1 = Frodo-640, 2 = Frodo-976, 3 = Frodo-1344; other codes are treated as 976/1344.
- REQ-007 SHALL have port i_mode, input, 1 bit: 0 = array sum; 1 = inner product of i_a and i_b.
- REQ-008 SHALL have port i_array, input, WIDTH*T bits: lane k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
- REQ-009 SHALL have ports i_a and i_b, input, WIDTH*T bits each, packed the same way as i_array.
- REQ-010 SHALL have port i_element, input, WIDTH bits: accumulator addend.
- REQ-011 SHALL have port o_element, output, WIDTH bits: result.
- REQ-012 SHALL have port o_valid, output, 1 bit: o_element is valid this cycle.

Function
- REQ-013 Mode 0 SHALL compute o_element = (i_element + sum over k of i_array[k]) mod 2^WIDTH, then apply the modulus mask.
- REQ-014 Mode 1 SHALL compute o_element = (i_element + sum over k of i_a[k]*i_b[k]) mod 2^WIDTH, then apply the mask. Each product is truncated to WIDTH bits.
- REQ-015 All intermediate adds SHALL be WIDTH bits wide and wrap modulo 2^WIDTH.
- REQ-016 Pipeline stage 1 SHALL register the per-lane operand: i_array[k] in mode 0, the product in mode 1.
- REQ-017 The pipeline SHALL then have log2(T) registered binary adder-tree levels.
- REQ-018 A final registered stage SHALL add i_element and apply the mask.
- REQ-019 Total latency SHALL be log2(T)+2 cycles from i_valid to o_valid; 6 cycles for T=16.
- REQ-020 i_mode, i_sec_lev and i_element SHALL be captured with the operands and travel alongside them, so back-to-back inputs with differing modes are independent.
- REQ-021 The block SHALL accept one new operand set every cycle, with no stall and no backpressure.
- REQ-022 o_valid SHALL be a delayed copy of i_valid. o_element SHALL hold its last value when o_valid is 0.
- REQ-023 The mask SHALL be: i_sec_lev = 1 clears bits WIDTH-1..15 (q = 2^15); any other code SHALL leave the result unmasked (q = 2^16 when WIDTH = 16).

Reset
- REQ-024 i_rst high SHALL immediately clear all pipeline registers, o_element and o_valid to 0.
- REQ-025 Operations in flight during reset SHALL be discarded, with no partial output.
- REQ-026 The first valid output after deassertion SHALL appear log2(T)+2 cycles after the first i_valid.

Configuration
- REQ-027 Macro TREE_ADD_SECLEV_MASK_EN: when defined, the mask in REQ-023 SHALL apply.
- REQ-028 When TREE_ADD_SECLEV_MASK_EN is undefined, o_element SHALL be the unmasked WIDTH-bit result and i_sec_lev SHALL be ignored.

Structure
- REQ-029 Security-level encodings (1/2/3) and per-level log2(q) constants SHALL live in the shared package frodo_pkg.
- REQ-030 A sub-module tree_add_lane SHALL implement the per-lane mode mux, the WIDTH-bit multiply and the stage-1 register. It SHALL be instantiated T times.

Verification (T=16, WIDTH=16, macro defined)
- REQ-031 i_array[k]=k, i_element=16, mode 0, sec_lev 1 -> o_element = 136 after 6 cycles.
- REQ-032 i_a[k]=i_b[k]=k, i_element=16, mode 1, sec_lev 1 -> o_element = 1256 after 6 cycles.
- REQ-033 All i_a=i_b=0xFFFF, i_element=0, mode 1 -> o_element = 16 (each product wraps to 1).
- REQ-034 All i_array=0x4000, i_element=0x8001, mode 0 -> o_element = 0x0001 for sec_lev 1 and 0x8001 for sec_lev 2.
- REQ-035 REQ-031 and REQ-032 issued on consecutive cycles -> 136 then 1256 on consecutive o_valid cycles.
- REQ-036 Assert i_rst 3 cycles after i_valid -> o_valid stays 0 and o_element = 0 until new valid input.
